rca_shift_add_multiplier: RTL and testbench
===========================================

# rca_shift_add_multiplier

Sequential unsigned WIDTH×WIDTH multiplier built on the existing ripple-carry adder as its only arithmetic element. It is the direct downstream consumer of the adder's Sum/Cout outputs. Each cycle, the adder adds the multiplicand to the upper half of a running partial product; a control FSM sequences WIDTH shift-and-add steps. Operands enter and the product leaves through valid/ready handshakes, so the block can sit between a register-file read stage and a writeback stage.

## Interface
- WIDTH, 8, operand width in bits; legal range WIDTH ≥ 2
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  operand pair a/b is valid
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts the product
- product  output  2*WIDTH  a*b, unsigned, registered

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load mcand=a, P={1'b0, WIDTH'b0, b} (2*WIDTH+1 bits), cnt=0; go to RUN.
- RUN (in_ready=0, out_valid=0), one step per cycle:
  - Adder inputs: A=P[2W-1:W], B=P[0] ? mcand : 0, Cin=0.
  - Update: P ← {1'b0, Cout, Sum, P[W-1:1]} (shift right by 1 with carry); cnt ← cnt+1.
  - When cnt reaches WIDTH-1 on the current step, the step completes, product ← new P[2W-1:0], and the FSM goes to DONE.
- DONE:
  - out_valid=1; product is held stable.
  - On out_valid&&out_ready, go to IDLE.
- Widths:
  - cnt is $clog2(WIDTH) bits.
  - Adder Cout is never lost; the full 2*WIDTH-bit result is exact (max (2^W−1)² fits).
- in_valid during RUN/DONE is ignored; no operand capture occurs.
- DONE with out_ready held low: remains in DONE indefinitely with product unchanged.
- DONE with in_valid high and out_ready high in the same cycle: only the DONE→IDLE transition occurs. The new pair can be accepted on the following cycle.
- Reset mid-operation: the next edge forces IDLE and discards the partial result. No output of the aborted operation ever appears.
- Zero operands still take the full WIDTH steps; latency is data-independent.

## Timing
- Reset values: in_ready=1, out_valid=0, product=0, state=IDLE, P=0, cnt=0, mcand=0.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- Latency: accept on edge E0, steps on E1..EW, out_valid high from edge EW.
  - out_valid is therefore high in the cycle following the W-th edge after acceptance: 8 edges for WIDTH=8.
- Earliest next acceptance is the edge after the output handshake edge, giving a minimum initiation interval of WIDTH+2 cycles.
- product changes only on the step-WIDTH edge and on reset. After returning to IDLE it holds the last result.

## Structure
- Shared package rca_pkg holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a default operand width constant;
  - the product width expression 2*WIDTH.
- One sub-module: generic_ripple_carry_adder_detailed_routing #(WIDTH), the existing adder, instantiated once.
- Everything else (FSM, cnt, P, mcand, product register) lives in rca_shift_add_multiplier.

## Test plan
- Reset: rst high for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, product=0 after release; no operand captured during reset.
- Basic, WIDTH=8: a=13, b=11 → out_valid rises exactly 8 edges after the accept edge, with product=143 (0x008F); a=0xAA, b=0x55 → 0x3872.
- Extremes: a=255, b=255 → 0xFE01 (carry into the top bit exercised); a=0, b=200 → 0x0000 with the same 8-edge latency.
- Backpressure: out_ready low for 5 cycles after done → out_valid stays 1, product stable.
  - A pair a=3, b=3 offered during RUN/DONE is not accepted (in_ready=0).
  - After the handshake, the pair is accepted one cycle later and yields 9.
- Simultaneous: in DONE, in_valid=1 and out_ready=1 in the same cycle → IDLE on the next edge, acceptance on the edge after that; no lost or duplicated result.
- Mid-op reset: a=100, b=100, rst pulsed during step 4 → IDLE, out_valid=0, product=0 on the next edge. A subsequent a=100, b=100 → 10000 (0x2710).

Source files
------------

// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rca_pkg
//  Description : Shared definitions for the ripple-carry shift-and-add
//                multiplier: FSM state encodings, default operand width and
//                the product width expression.
//  Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

  // Default operand width used when the multiplier is not overridden
  localparam int DEFAULT_WIDTH = 8;

  // Control FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // An unsigned WxW product needs exactly 2*W bits
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/generic_ripple_carry_adder_detailed_routing.sv
`default_nettype none
// ============================================================================
//  Module      : generic_ripple_carry_adder_detailed_routing
//  Description : WIDTH-bit ripple-carry adder built from a chain of full
//                adders; carry-in enters bit 0, carry-out leaves the MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module generic_ripple_carry_adder_detailed_routing #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Carry chain: carry[i] enters bit i, carry[WIDTH] is the final carry-out
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // One full adder per bit position
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/rca_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : rca_shift_add_multiplier
//  Description : Sequential unsigned WIDTHxWIDTH shift-and-add multiplier.
//                One ripple-carry adder step per cycle adds the multiplicand
//                into the upper half of the running partial product, which
//                then shifts right with the adder carry. Valid/ready
//                handshakes on both operand input and product output.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_shift_add_multiplier
  import rca_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  // Control and datapath state
  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  // Partial product: the conceptual extra MSB above bit 2W-1 is always zero
  // after every shift, so only the lower 2W bits are stored.
  logic [PW-1:0]    p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;

  // Adder hookup
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign add_a = p_q[PW-1:WIDTH];
  assign add_b = p_q[0] ? mcand_q : '0;

  generic_ripple_carry_adder_detailed_routing #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State and datapath registers, cleared synchronously
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state logic: accept in IDLE, WIDTH steps in RUN, hold in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST_STEP) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-and-add step, product latch on last step
  always_comb begin
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
        end
      end
      RUN: begin
        p_d   = {add_cout, add_sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          product_d = p_d;
        end
      end
      default: begin
      end
    endcase
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    product   = product_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_rca_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca_shift_add_multiplier
//  Description : Scoreboard bench for rca_shift_add_multiplier. The driver
//                pushes a*b (plain arithmetic) with the accept edge index;
//                an independent monitor pops on each output handshake and
//                checks product, latency and product stability.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_shift_add_multiplier;

  localparam int WIDTH = 8;

  typedef struct {
    logic [2*WIDTH-1:0] prod;
    longint             acc;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  logic               or_drv;
  logic               or_rand;
  logic               rand_bp;

  int                 n_tests;
  int                 n_fail;
  longint             cyc;
  longint             last_acc;
  longint             last_hs;
  exp_t               exp_q[$];
  bit                 out_seen;
  logic [2*WIDTH-1:0] last_prod;

  rca_shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  assign out_ready = rand_bp ? or_rand : or_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    or_rand = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented output against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      out_seen  = 1'b0;
      last_prod = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: product 0x%0h with nothing pending", product);
      end else begin
        if (!out_seen) begin
          check("latency", 64'(cyc - exp_q[0].acc), 64'(WIDTH));
          out_seen = 1'b1;
        end
        check("product", 64'(product), 64'(exp_q[0].prod));
        check("in_ready_in_done", 64'(in_ready), 64'd0);
        if (out_ready) begin
          last_prod = exp_q[0].prod;
          void'(exp_q.pop_front());
          out_seen = 1'b0;
          last_hs  = cyc + 1;
        end
      end
    end else begin
      check("product_hold", 64'(product), 64'(last_prod));
    end
  end

  // Offer a pair and wait (bounded) for acceptance; records the accept edge
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib);
    bit   ok;
    exp_t it;
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for a=%0d b=%0d", ia, ib);
      in_valid = 1'b0;
      return;
    end
    it.prod  = (2*WIDTH)'(ia) * (2*WIDTH)'(ib);
    it.acc   = cyc + 1;
    last_acc = it.acc;
    exp_q.push_back(it);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
  endtask

  task automatic wait_out_valid();
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_valid_timeout: out_valid stayed 0");
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    last_acc = 0;
    last_hs  = 0;
    out_seen = 1'b0;
    last_prod = '0;
    rand_bp  = 1'b0;
    or_drv   = 1'b1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'd5;
    b        = 8'd5;

    // Reset held for two edges with in_valid high
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("no_capture_in_ready", 64'(in_ready), 64'd1);

    // Directed patterns including extremes and zero operand
    issue(8'd13, 8'd11);
    drain();
    issue(8'hAA, 8'h55);
    drain();
    issue(8'd255, 8'd255);
    drain();
    issue(8'd0, 8'd200);
    drain();

    // Backpressure, plus a pair offered during RUN/DONE
    or_drv = 1'b0;
    issue(8'd21, 8'd12);
    in_valid = 1'b1;
    a        = 8'd3;
    b        = 8'd3;
    @(negedge clk);
    check("bp_in_ready_run", 64'(in_ready), 64'd0);
    wait_out_valid();
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready_done", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    or_drv = 1'b1;
    issue(8'd3, 8'd3);
    check("bp_accept_after_hs", 64'(last_acc), 64'(last_hs + 1));
    drain();

    // Simultaneous in_valid and out_ready while in DONE
    or_drv = 1'b0;
    issue(8'd7, 8'd9);
    wait_out_valid();
    @(posedge clk);
    #1;
    or_drv = 1'b1;
    issue(8'd200, 8'd3);
    check("sim_accept_after_hs", 64'(last_acc), 64'(last_hs + 1));
    drain();

    // Reset pulsed so that it lands on step 4
    issue(8'd100, 8'd100);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_product", 64'(product), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    issue(8'd100, 8'd100);
    drain();

    // Randomized operands with random output backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom));
    end
    rand_bp = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
